p4_mem_access: RTL and testbench

// - Memory-access stage: consumes the decoded bundle from decode/register-read (memwrite, address,

---
 rtl/p4_mem_access.sv | 92 +++++++++
 tb/tb_p4_mem_access.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/p4_mem_access.sv
// p4_mem_access: memory-access stage with load/store FSM; DMEM_TIMEOUT_EN enables ack timeout abort with sticky dmem_err
module p4_mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [1:0]  memwrite,
  input  logic [15:0] address,
  input  logic [15:0] storedata,
  input  logic        writereg,
  input  logic [2:0]  regaddress,
  input  logic [15:0] aluresult,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        writeflag,
  output logic [2:0]  writetarget,
  output logic        readoutSelect,
  output logic [15:0] readoutwriteval,
  output logic [15:0] aluwriteval,
  output logic        dmem_err
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic accept_alu, accept_mem, done, timeout, lat_wr;
  logic [2:0] lat_ra;
  assign stall = state == ACCESS;
  always_comb begin
    accept_alu = state == IDLE && valid_in && (memwrite == 2'b00 || memwrite == 2'b11);
    accept_mem = state == IDLE && valid_in && (memwrite == 2'b01 || memwrite == 2'b10);
    done = state == ACCESS && dmem_ack;
    state_nx = accept_mem ? ACCESS : (done || timeout) ? IDLE : state;
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_nx;
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  assign timeout = state == ACCESS && !dmem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock) begin
    cnt <= (reset || state != ACCESS) ? '0 : cnt + 1'b1;
    dmem_err <= reset ? 1'b0 : dmem_err | timeout;
  end
`else
  assign timeout = 1'b0;
  assign dmem_err = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      wb_valid <= 1'b0;
      writeflag <= 1'b0;
      writetarget <= '0;
      readoutSelect <= 1'b0;
      readoutwriteval <= '0;
      aluwriteval <= '0;
      lat_wr <= 1'b0;
      lat_ra <= '0;
    end else begin
      wb_valid <= accept_alu || done || timeout;
      writeflag <= accept_alu ? writereg : done && lat_wr && !dmem_we;
      if (accept_alu) begin
        writetarget <= regaddress;
        readoutSelect <= 1'b0;
        aluwriteval <= aluresult;
      end
      if (accept_mem) begin
        dmem_req <= 1'b1;
        dmem_we <= memwrite == 2'b10;
        dmem_addr <= address;
        dmem_wdata <= memwrite == 2'b10 ? storedata : '0;
        lat_wr <= writereg;
        lat_ra <= regaddress;
      end
      if (done || timeout) dmem_req <= 1'b0;
      // stores leave the register-side writeback fields untouched
      if (done && !dmem_we) begin
        writetarget <= lat_ra;
        readoutSelect <= 1'b1;
        readoutwriteval <= dmem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_p4_mem_access.sv
// tb_p4_mem_access: randomized self-checking bench against a last-writeback reference model
module tb_p4_mem_access;
  localparam int TO = 4;
  logic clock = 0, reset = 1, valid_in = 0, writereg = 0, dmem_ack = 0;
  logic [1:0] memwrite = 0;
  logic [2:0] regaddress = 0;
  logic [15:0] address = 0, storedata = 0, aluresult = 0, dmem_rdata = 0;
  logic stall, dmem_req, dmem_we, wb_valid, writeflag, readoutSelect, dmem_err;
  logic [2:0] writetarget;
  logic [15:0] dmem_addr, dmem_wdata, readoutwriteval, aluwriteval;
  int n_checks = 0, n_fail = 0;
  logic [2:0] m_target = 0;
  logic m_sel = 0;
  logic [15:0] m_rval = 0, m_aval = 0;
  p4_mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .memwrite(memwrite), .address(address),
    .storedata(storedata), .writereg(writereg), .regaddress(regaddress), .aluresult(aluresult),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
    .writeflag(writeflag), .writetarget(writetarget), .readoutSelect(readoutSelect),
    .readoutwriteval(readoutwriteval), .aluwriteval(aluwriteval), .dmem_err(dmem_err)
  );
  always #5 clock = ~clock;
  wire [37:0] wb_bus = {wb_valid, writeflag, writetarget, readoutSelect, readoutwriteval, aluwriteval};
  wire [34:0] mem_bus = {stall, dmem_req, dmem_we, dmem_addr, dmem_wdata};
  task automatic clear_model;
    m_target = 0; m_sel = 0; m_rval = 0; m_aval = 0;
  endtask
  task automatic alu_op(input logic [1:0] mw, input logic wr, input logic [2:0] ra, input logic [15:0] res);
    valid_in = 1; memwrite = mw; writereg = wr; regaddress = ra; aluresult = res;
    address = 16'($urandom); storedata = 16'($urandom);
    @(negedge clock);
    valid_in = 0;
    m_target = ra; m_sel = 0; m_aval = res;
    n_checks++;
    if ({wb_bus, stall, dmem_req} !== {1'b1, wr, m_target, m_sel, m_rval, m_aval, 2'b00}) begin
      n_fail++; $display("FAIL alu_wb: got %h required %h", {wb_bus, stall, dmem_req}, {1'b1, wr, m_target, m_sel, m_rval, m_aval, 2'b00});
    end
    @(negedge clock);
    n_checks++;
    if (wb_bus !== {2'b00, m_target, m_sel, m_rval, m_aval}) begin
      n_fail++; $display("FAIL alu_idle: got %h required %h", wb_bus, {2'b00, m_target, m_sel, m_rval, m_aval});
    end
  endtask
  task automatic mem_op(input logic st, input logic [15:0] a, input logic [15:0] d, input logic wr,
                        input logic [2:0] ra, input int waits, input logic [15:0] rd);
    logic [35:0] exp_acc;
    valid_in = 1; memwrite = st ? 2'b10 : 2'b01; address = a; storedata = d; writereg = wr;
    regaddress = ra; aluresult = 16'($urandom);
    @(negedge clock);
    valid_in = 0;
    exp_acc = {2'b11, st, a, st ? d : 16'h0000, 1'b0};
    for (int i = 0; i <= waits; i++) begin
      n_checks++;
      if ({mem_bus, wb_valid} !== exp_acc) begin
        n_fail++; $display("FAIL mem_access cycle %0d: got %h required %h", i, {mem_bus, wb_valid}, exp_acc);
      end
      address = 16'($urandom); storedata = 16'($urandom);
      dmem_ack = i == waits; dmem_rdata = i == waits ? rd : 16'($urandom);
      @(negedge clock);
    end
    dmem_ack = 0;
    if (!st) begin m_target = ra; m_sel = 1; m_rval = rd; end
    n_checks++;
    if ({stall, dmem_req, wb_bus} !== {2'b00, 1'b1, !st && wr, m_target, m_sel, m_rval, m_aval}) begin
      n_fail++; $display("FAIL mem_wb: got %h required %h", {stall, dmem_req, wb_bus}, {2'b00, 1'b1, !st && wr, m_target, m_sel, m_rval, m_aval});
    end
    @(negedge clock);
    n_checks++;
    if (wb_bus !== {2'b00, m_target, m_sel, m_rval, m_aval}) begin
      n_fail++; $display("FAIL mem_idle: got %h required %h", wb_bus, {2'b00, m_target, m_sel, m_rval, m_aval});
    end
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
    clear_model();
    n_checks++;
    if ({wb_bus, mem_bus, dmem_err} !== '0) begin
      n_fail++; $display("FAIL reset_state: got %h required 0", {wb_bus, mem_bus, dmem_err});
    end
  endtask
  task automatic test_alu;
    alu_op(2'b00, 1'b1, 3'd3, 16'h1234);
    alu_op(2'b11, 1'b0, 3'd0, 16'hFFFF);
    for (int i = 0; i < 6; i++) alu_op($urandom_range(0, 1) ? 2'b11 : 2'b00, 1'($urandom), 3'($urandom), 16'($urandom));
  endtask
  task automatic test_load;
    mem_op(1'b0, 16'h0040, 16'h0000, 1'b1, 3'd5, 2, 16'hBEEF);
    for (int i = 0; i < 5; i++)
      mem_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), $urandom_range(0, 5), 16'($urandom));
  endtask
  task automatic test_store;
    mem_op(1'b1, 16'h0010, 16'h00A5, 1'b1, 3'd2, 0, 16'h1357);
    for (int i = 0; i < 4; i++)
      mem_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), $urandom_range(0, 4), 16'($urandom));
    alu_op(2'b00, 1'b1, 3'd7, 16'($urandom));
  endtask
  task automatic test_back_to_back;
    valid_in = 1; memwrite = 2'b00; writereg = 1; regaddress = 3'd1; aluresult = 16'h1111;
    @(negedge clock);
    m_target = 1; m_sel = 0; m_aval = 16'h1111;
    n_checks++;
    if (wb_bus !== {2'b11, m_target, m_sel, m_rval, m_aval}) begin
      n_fail++; $display("FAIL b2b_alu1: got %h required %h", wb_bus, {2'b11, m_target, m_sel, m_rval, m_aval});
    end
    memwrite = 2'b01; address = 16'h0200; regaddress = 3'd2;
    @(negedge clock);
    n_checks++;
    if ({mem_bus, wb_valid} !== {2'b11, 1'b0, 16'h0200, 16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL b2b_access: got %h required %h", {mem_bus, wb_valid}, {2'b11, 1'b0, 16'h0200, 16'h0000, 1'b0});
    end
    memwrite = 2'b00; regaddress = 3'd4; aluresult = 16'h4444; dmem_ack = 1; dmem_rdata = 16'h2222;
    @(negedge clock);
    dmem_ack = 0;
    m_target = 2; m_sel = 1; m_rval = 16'h2222;
    n_checks++;
    if ({stall, dmem_req, wb_bus} !== {2'b00, 2'b11, m_target, m_sel, m_rval, m_aval}) begin
      n_fail++; $display("FAIL b2b_load: got %h required %h", {stall, dmem_req, wb_bus}, {2'b00, 2'b11, m_target, m_sel, m_rval, m_aval});
    end
    @(negedge clock);
    valid_in = 0;
    m_target = 4; m_sel = 0; m_aval = 16'h4444;
    n_checks++;
    if (wb_bus !== {2'b11, m_target, m_sel, m_rval, m_aval}) begin
      n_fail++; $display("FAIL b2b_alu2: got %h required %h", wb_bus, {2'b11, m_target, m_sel, m_rval, m_aval});
    end
    dmem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if ({stall, dmem_req, wb_bus} !== {4'b0000, m_target, m_sel, m_rval, m_aval}) begin
        n_fail++; $display("FAIL spurious_ack %0d: got %h required %h", i, {stall, dmem_req, wb_bus}, {4'b0000, m_target, m_sel, m_rval, m_aval});
      end
    end
    dmem_ack = 0;
  endtask
  task automatic test_reset_access;
    valid_in = 1; memwrite = 2'b01; address = 16'h0300; regaddress = 3'd6; writereg = 1;
    @(negedge clock);
    valid_in = 0;
    n_checks++;
    if ({stall, dmem_req} !== 2'b11) begin
      n_fail++; $display("FAIL rst_pre: got %b required 11", {stall, dmem_req});
    end
    reset = 1;
    @(negedge clock);
    reset = 0;
    clear_model();
    dmem_ack = 1; dmem_rdata = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({stall, dmem_req, wb_valid, writeflag} !== 4'b0000) begin
        n_fail++; $display("FAIL rst_abort %0d: got %b required 0000", i, {stall, dmem_req, wb_valid, writeflag});
      end
      @(negedge clock);
    end
    dmem_ack = 0;
  endtask
  task automatic test_timeout;
    valid_in = 1; memwrite = 2'b01; address = 16'h0404; regaddress = 3'd1; writereg = 1;
    @(negedge clock);
    valid_in = 0;
`ifdef DMEM_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      n_checks++;
      if ({stall, dmem_req, wb_valid} !== 3'b110) begin
        n_fail++; $display("FAIL to_wait %0d: got %b required 110", i, {stall, dmem_req, wb_valid});
      end
      @(negedge clock);
    end
    n_checks++;
    if ({stall, dmem_req, wb_valid, writeflag, dmem_err} !== 5'b00101) begin
      n_fail++; $display("FAIL to_abort: got %b required 00101", {stall, dmem_req, wb_valid, writeflag, dmem_err});
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if ({wb_valid, dmem_err} !== 2'b01) begin
      n_fail++; $display("FAIL to_sticky: got %b required 01", {wb_valid, dmem_err});
    end
    test_reset();
`else
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if ({stall, dmem_req, wb_valid, dmem_err} !== 4'b1100) begin
        n_fail++; $display("FAIL no_timeout %0d: got %b required 1100", i, {stall, dmem_req, wb_valid, dmem_err});
      end
      @(negedge clock);
    end
    dmem_ack = 1; dmem_rdata = 16'h5A5A;
    @(negedge clock);
    dmem_ack = 0;
    n_checks++;
    if ({wb_valid, writeflag, readoutwriteval, dmem_err} !== {2'b11, 16'h5A5A, 1'b0}) begin
      n_fail++; $display("FAIL late_ack: got %h required %h", {wb_valid, writeflag, readoutwriteval, dmem_err}, {2'b11, 16'h5A5A, 1'b0});
    end
`endif
  endtask
  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_access();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
